vending_coin_feeder: RTL and testbench

Payment initiator for the vending machine's coin interface. On a `start` request it snapshots a wallet of one-unit and half-unit coins and drives one coin pulse per cycle on `pi_money_one` / `pi_money_half` until the price is covered. It then waits for the machine's `po_beverage` / `po_money` response and reports whether the purchase succeeded and whether change was correctly returned. It sits between the customer-side controller (or bench) and the vending machine, and drives the machine's inputs.

---
 rtl/vending_coin_feeder.sv | 204 ++++++++++++++++++++
 tb/tb_vending_coin_feeder.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/vending_coin_feeder.sv
// Payment initiator for the vending machine coin interface: pays a fixed price from a
// snapshotted wallet one coin per cycle, then checks the machine's beverage/change response.
//
// state | meaning
// IDLE  | waiting for start; held results stay visible
// FEED  | one coin pulse per cycle until the price is covered
// WAIT  | coins done, waiting for po_beverage or timeout
// DONE  | one-cycle done pulse, then back to IDLE
module vending_coin_feeder #(
    parameter int PRICE_HALF = 5,
    parameter int TIMEOUT    = 15
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       start,
    input  logic [3:0] wallet_one,
    input  logic [3:0] wallet_half,
    input  logic       po_beverage,
    input  logic       po_money,
    output logic       pi_money_one,
    output logic       pi_money_half,
    output logic       busy,
    output logic       done,
    output logic       success,
    output logic       change_got,
    output logic [1:0] status,
    output logic [5:0] paid_half
);

    localparam logic [5:0] PRICE    = 6'(PRICE_HALF);
    localparam logic [7:0] WAIT_TC  = 8'(TIMEOUT - 1);

    localparam logic [1:0] ST_OK       = 2'd0;
    localparam logic [1:0] ST_NO_FUNDS = 2'd1;
    localparam logic [1:0] ST_TIMEOUT  = 2'd2;
    localparam logic [1:0] ST_CHANGE   = 2'd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FEED,
        S_WAIT,
        S_DONE
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] wal_one_q, wal_one_d;
    logic [3:0] wal_half_q, wal_half_d;
    logic [5:0] paid_q, paid_d;
    logic [7:0] wait_cnt_q, wait_cnt_d;
    logic       one_q, one_d;
    logic       half_q, half_d;
    logic       busy_q, busy_d;
    logic       done_q, done_d;
    logic       success_q, success_d;
    logic       change_q, change_d;
    logic [1:0] status_q, status_d;

    // Coin choice works off the live wallet inputs on the accepting edge, else the snapshot.
    logic [3:0] src_one;
    logic [3:0] src_half;
    logic [5:0] src_paid;
    logic [5:0] funds;
    logic       need_two;
    logic       pick_one;
    logic       expect_change;

    always_comb begin
        src_one  = wal_one_q;
        src_half = wal_half_q;
        src_paid = paid_q;
        if (state_q == S_IDLE) begin
            src_one  = wallet_one;
            src_half = wallet_half;
            src_paid = 6'd0;
        end
        funds         = {1'b0, wallet_one, 1'b0} + {2'b00, wallet_half};
        need_two      = ({1'b0, src_paid} + 7'd2) <= {1'b0, PRICE};
        pick_one      = (need_two && (src_one != 4'd0)) || (src_half == 4'd0);
        expect_change = paid_q > PRICE;
    end

    always_comb begin
        state_d    = state_q;
        wal_one_d  = wal_one_q;
        wal_half_d = wal_half_q;
        paid_d     = paid_q;
        wait_cnt_d = wait_cnt_q;
        one_d      = 1'b0;
        half_d     = 1'b0;
        busy_d     = busy_q;
        done_d     = 1'b0;
        success_d  = success_q;
        change_d   = change_q;
        status_d   = status_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    wal_one_d  = wallet_one;
                    wal_half_d = wallet_half;
                    paid_d     = 6'd0;
                    success_d  = 1'b0;
                    change_d   = 1'b0;
                    status_d   = ST_OK;
                    busy_d     = 1'b1;
                    if (funds < PRICE) begin
                        state_d  = S_DONE;
                        status_d = ST_NO_FUNDS;
                        done_d   = 1'b1;
                    end else begin
                        state_d = S_FEED;
                    end
                end
            end
            S_FEED: begin
                if (paid_q >= PRICE) begin
                    state_d    = S_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            S_WAIT: begin
                if (po_beverage) begin
                    state_d  = S_DONE;
                    done_d   = 1'b1;
                    change_d = po_money;
                    if (po_money == expect_change) begin
                        status_d  = ST_OK;
                        success_d = 1'b1;
                    end else begin
                        status_d  = ST_CHANGE;
                        success_d = 1'b0;
                    end
                end else if (wait_cnt_q == WAIT_TC) begin
                    state_d   = S_DONE;
                    done_d    = 1'b1;
                    status_d  = ST_TIMEOUT;
                    success_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
            default: state_d = S_IDLE;
        endcase

        // A coin goes out on the accepting edge and on every FEED edge still short of the price.
        if (state_d == S_FEED && (state_q == S_IDLE || paid_q < PRICE)) begin
            if (pick_one) begin
                one_d      = 1'b1;
                wal_one_d  = src_one - {3'b000, (src_one != 4'd0)};
                wal_half_d = src_half;
                paid_d     = src_paid + 6'd2;
            end else begin
                half_d     = 1'b1;
                wal_one_d  = src_one;
                wal_half_d = src_half - 4'd1;
                paid_d     = src_paid + 6'd1;
            end
        end
    end

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            state_q    <= S_IDLE;
            wal_one_q  <= 4'd0;
            wal_half_q <= 4'd0;
            paid_q     <= 6'd0;
            wait_cnt_q <= 8'd0;
            one_q      <= 1'b0;
            half_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            success_q  <= 1'b0;
            change_q   <= 1'b0;
            status_q   <= ST_OK;
        end else begin
            state_q    <= state_d;
            wal_one_q  <= wal_one_d;
            wal_half_q <= wal_half_d;
            paid_q     <= paid_d;
            wait_cnt_q <= wait_cnt_d;
            one_q      <= one_d;
            half_q     <= half_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            success_q  <= success_d;
            change_q   <= change_d;
            status_q   <= status_d;
        end
    end

    assign pi_money_one  = one_q;
    assign pi_money_half = half_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign success       = success_q;
    assign change_got    = change_q;
    assign status        = status_q;
    assign paid_half     = paid_q;

endmodule

// File: tb/tb_vending_coin_feeder.sv
// Self-checking bench for vending_coin_feeder: table of purchases with a coin/result
// scoreboard, plus hand-written reset and held-start sequences.
module tb_vending_coin_feeder;

    localparam int PRICE = 5;
    localparam int TMO   = 15;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       start;
    logic [3:0] wallet_one;
    logic [3:0] wallet_half;
    logic       po_beverage;
    logic       po_money;
    logic       pi_money_one;
    logic       pi_money_half;
    logic       busy;
    logic       done;
    logic       success;
    logic       change_got;
    logic [1:0] status;
    logic [5:0] paid_half;

    vending_coin_feeder #(.PRICE_HALF(PRICE), .TIMEOUT(TMO)) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .start         (start),
        .wallet_one    (wallet_one),
        .wallet_half   (wallet_half),
        .po_beverage   (po_beverage),
        .po_money      (po_money),
        .pi_money_one  (pi_money_one),
        .pi_money_half (pi_money_half),
        .busy          (busy),
        .done          (done),
        .success       (success),
        .change_got    (change_got),
        .status        (status),
        .paid_half     (paid_half)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // resp: WAIT cycle in which the machine answers (0 = silent); noise drives po_beverage during FEED.
    typedef struct {
        int         w1;
        int         wh;
        int         resp;
        logic       money;
        logic       noise;
        logic [1:0] st;
        logic       succ;
        logic       chg;
        logic [5:0] paid;
    } vec_t;

    typedef struct {
        logic is_one;
        int   cyc;
    } coin_t;

    typedef struct {
        logic [1:0] st;
        logic       succ;
        logic       chg;
        logic [5:0] paid;
        int         done_cyc;
    } res_t;

    coin_t coin_q[$];
    res_t  res_q[$];
    int    n_tests = 0;
    int    n_fail  = 0;
    logic [13:0] outs;

    assign outs = {pi_money_one, pi_money_half, busy, done, success, change_got, status, paid_half};

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_case(input vec_t v, input int idx);
        int    w1;
        int    wh;
        int    paid;
        int    n;
        int    done_cyc;
        bit    got_done;
        coin_t c;
        res_t  r;
        w1 = v.w1;
        wh = v.wh;
        paid = 0;
        n = 0;
        if (2 * w1 + wh >= PRICE) begin
            while (paid < PRICE) begin
                n++;
                if (PRICE - paid >= 2 && w1 > 0) begin
                    w1--; paid += 2; coin_q.push_back('{1'b1, n});
                end else if (wh > 0) begin
                    wh--; paid += 1; coin_q.push_back('{1'b0, n});
                end else begin
                    w1--; paid += 2; coin_q.push_back('{1'b1, n});
                end
            end
        end
        done_cyc = (n == 0) ? 1 : n + ((v.resp == 0) ? TMO : v.resp) + 1;
        res_q.push_back('{v.st, v.succ, v.chg, v.paid, done_cyc});

        @(negedge sys_clk);
        wallet_one  = 4'(v.w1);
        wallet_half = 4'(v.wh);
        start       = 1'b1;
        @(negedge sys_clk);
        start    = 1'b0;
        got_done = 1'b0;
        for (int cyc = 1; cyc <= 60; cyc++) begin
            if (cyc > 1) @(negedge sys_clk);
            check($sformatf("case%0d busy c%0d", idx, cyc), int'(busy), 1);
            check($sformatf("case%0d coin overlap c%0d", idx, cyc), int'(pi_money_one & pi_money_half), 0);
            if (pi_money_one || pi_money_half) begin
                if (coin_q.size() == 0) begin
                    check($sformatf("case%0d extra coin c%0d", idx, cyc), 1, 0);
                end else begin
                    c = coin_q.pop_front();
                    check($sformatf("case%0d coin kind c%0d", idx, cyc), int'(pi_money_one), int'(c.is_one));
                    check($sformatf("case%0d coin cycle", idx), cyc, c.cyc);
                end
            end
            if (done) begin
                r = res_q.pop_front();
                check($sformatf("case%0d done cycle", idx), cyc, r.done_cyc);
                check($sformatf("case%0d status", idx), int'(status), int'(r.st));
                check($sformatf("case%0d success", idx), int'(success), int'(r.succ));
                check($sformatf("case%0d change_got", idx), int'(change_got), int'(r.chg));
                check($sformatf("case%0d paid_half", idx), int'(paid_half), int'(r.paid));
                got_done = 1'b1;
                po_beverage = 1'b0;
                po_money    = 1'b0;
                break;
            end
            po_beverage = (v.noise && cyc <= n) || (v.resp != 0 && cyc == n + v.resp);
            po_money    = v.money;
        end
        po_beverage = 1'b0;
        po_money    = 1'b0;
        if (!got_done) begin
            check($sformatf("case%0d done never seen", idx), 0, 1);
            res_q.delete();
        end
        check($sformatf("case%0d coins missing", idx), coin_q.size(), 0);
        coin_q.delete();
        @(negedge sys_clk);
        check($sformatf("case%0d done after pulse", idx), int'(done), 0);
        check($sformatf("case%0d busy after done", idx), int'(busy), 0);
        check($sformatf("case%0d status held", idx), int'(status), int'(v.st));
        check($sformatf("case%0d success held", idx), int'(success), int'(v.succ));
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = '{2,  1,  1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 6'd5};
        tbl[1]  = '{3,  0,  2, 1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 6'd6};
        tbl[2]  = '{1,  2,  0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 6'd0};
        tbl[3]  = '{2,  1,  0, 1'b0, 1'b0, 2'd2, 1'b0, 1'b0, 6'd5};
        tbl[4]  = '{2,  1,  1, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 6'd5};
        tbl[5]  = '{0,  5, 15, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 6'd5};
        tbl[6]  = '{3,  0,  1, 1'b0, 1'b0, 2'd3, 1'b0, 1'b0, 6'd6};
        tbl[7]  = '{1,  3,  3, 1'b0, 1'b1, 2'd0, 1'b1, 1'b0, 6'd5};
        tbl[8]  = '{15, 15, 1, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 6'd5};
        tbl[9]  = '{0,  4,  0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 6'd0};
        tbl[10] = '{2,  0,  0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 6'd0};
        tbl[11] = '{0,  0,  0, 1'b0, 1'b0, 2'd1, 1'b0, 1'b0, 6'd0};
        tbl[12] = '{4,  0,  4, 1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 6'd6};
        tbl[13] = '{1,  4,  2, 1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 6'd5};

        sys_rst_n   = 1'b0;
        start       = 1'b0;
        wallet_one  = 4'd0;
        wallet_half = 4'd0;
        po_beverage = 1'b0;
        po_money    = 1'b0;
        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        check("reset outputs", int'(outs), 0);
        sys_rst_n = 1'b1;

        for (int i = 0; i < 14; i++) run_case(tbl[i], i);

        // Reset after the second coin: nothing more may come out.
        @(negedge sys_clk);
        wallet_one  = 4'd2;
        wallet_half = 4'd1;
        start       = 1'b1;
        @(negedge sys_clk);
        start = 1'b0;
        check("rst seq coin1", int'(pi_money_one), 1);
        @(negedge sys_clk);
        check("rst seq coin2", int'(pi_money_one), 1);
        check("rst seq paid before reset", int'(paid_half), 4);
        sys_rst_n = 1'b0;
        @(negedge sys_clk);
        check("rst seq outputs cleared", int'(outs), 0);
        sys_rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge sys_clk);
            check($sformatf("rst seq idle c%0d", i), int'(outs), 0);
        end
        run_case(tbl[0], 100);

        // start held high: a new purchase is accepted on the first IDLE edge after DONE.
        @(negedge sys_clk);
        wallet_one  = 4'd0;
        wallet_half = 4'd0;
        start       = 1'b1;
        for (int cyc = 1; cyc <= 4; cyc++) begin
            @(negedge sys_clk);
            if (cyc == 3) start = 1'b0;
            check($sformatf("held start done c%0d", cyc), int'(done), (cyc % 2 == 1) ? 1 : 0);
            check($sformatf("held start busy c%0d", cyc), int'(busy), (cyc % 2 == 1) ? 1 : 0);
            check($sformatf("held start status c%0d", cyc), int'(status), 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
